boot_loader: RTL and testbench

//  Sits between the cpu memory port and the program/data RAM. After reset it holds the cpu in reset.
//  It receives a program image as a byte stream (valid/ready), writes it into RAM as halfwords,

---
 rtl/boot_loader.sv | 165 ++++++++++++++++
 tb/tb_boot_loader.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/boot_loader.sv
// Boot loader: holds the cpu in reset, streams a length-prefixed,
// checksummed program image into RAM as halfwords, then releases the
// cpu and hands the RAM port straight through to it.

// One RAM byte lane: selects between the cpu port and the loader's
// registered write.
module boot_loader_lane (
  input  logic       sel_cpu,
  input  logic [7:0] cpu_di,
  input  logic       cpu_we,
  input  logic [7:0] ldr_di,
  input  logic       ldr_we,
  output logic [7:0] mem_di,
  output logic       mem_we
);
  assign mem_di = sel_cpu ? cpu_di : ldr_di;
  assign mem_we = sel_cpu ? cpu_we : ldr_we;
endmodule

module boot_loader #(
  parameter int MEM_DEPTH  = 2**12,
  localparam int ADDR_WIDTH = $clog2(MEM_DEPTH*2)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic                  i_bypass,
  input  logic [7:0]            i_byte,
  input  logic                  i_byte_valid,
  output logic                  o_byte_ready,
  input  logic [0:1][7:0]       i_cpu_mem_di,
  input  logic [ADDR_WIDTH-1:0] i_cpu_mem_addr,
  input  logic                  i_cpu_mem_en,
  input  logic                  i_cpu_mem_rd_en,
  input  logic [0:1]            i_cpu_mem_wr_en,
  output logic [0:1][7:0]       o_mem_di,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_en,
  output logic                  o_mem_rd_en,
  output logic [0:1]            o_mem_wr_en,
  output logic                  o_cpu_rst,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err
);
  localparam int NUM_LANES = 2;
  localparam int IDX_W     = ADDR_WIDTH - 1;
  // Length is 16 bits on the wire; one extra bit keeps N-1 and the
  // depth limit comparable without wrap.
  localparam logic [16:0] DEPTH_L = 17'(MEM_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHK, S_DONE, S_ERR
  } state_t;

  typedef struct packed {
    logic                  en;
    logic [ADDR_WIDTH-1:0] addr;
    logic [0:1][7:0]       di;
  } wr_req_t;

  state_t          state, nxt;
  logic [15:0]     len;
  logic [IDX_W-1:0] idx;
  logic [7:0]      chk;
  logic [7:0]      d0;
  wr_req_t         wr;

  logic        hs;
  logic [16:0] n_full;
  logic        last;

  assign hs     = i_byte_valid & o_byte_ready;
  // Full length as it will be once LEN_LO is accepted this cycle.
  assign n_full = {1'b0, len[15:8], i_byte};
  assign last   = (17'(idx) == ({1'b0, len} - 17'd1));

  // Next-state decode; the register block below owns all state.
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:    if (i_start) nxt = S_LEN_HI;
                 else if (i_bypass) nxt = S_DONE;
      S_LEN_HI:  if (hs) nxt = S_LEN_LO;
      S_LEN_LO:  if (hs) begin
                   if (n_full > DEPTH_L)    nxt = S_ERR;
                   else if (n_full == '0)   nxt = S_CHK;
                   else                     nxt = S_DATA_HI;
                 end
      S_DATA_HI: if (hs) nxt = S_DATA_LO;
      S_DATA_LO: if (hs) nxt = last ? S_CHK : S_DATA_HI;
      S_CHK:     if (hs) nxt = (i_byte == chk) ? S_DONE : S_ERR;
      S_DONE:    nxt = S_DONE;
      S_ERR:     if (i_start) nxt = S_LEN_HI;
      default:   nxt = S_IDLE;
    endcase
  end

  // FSM state, load datapath, one-cycle write strobe and registered status.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      len          <= '0;
      idx          <= '0;
      chk          <= '0;
      d0           <= '0;
      wr           <= '0;
      o_byte_ready <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_err        <= 1'b0;
      o_cpu_rst    <= 1'b1;
    end else begin
      state <= nxt;
      wr    <= '0;
      case (state)
        S_IDLE, S_ERR: if (nxt == S_LEN_HI) begin
          len <= '0;
          idx <= '0;
          chk <= '0;
        end
        S_LEN_HI: if (hs) len[15:8] <= i_byte;
        S_LEN_LO: if (hs) begin
          len[7:0] <= i_byte;
          idx      <= '0;
          chk      <= '0;
        end
        S_DATA_HI: if (hs) begin
          d0  <= i_byte;
          chk <= chk ^ i_byte;
        end
        S_DATA_LO: if (hs) begin
          chk     <= chk ^ i_byte;
          wr.en   <= 1'b1;
          wr.addr <= {idx, 1'b0};
          wr.di   <= {d0, i_byte};
          idx     <= idx + 1'b1;
        end
        default: ;
      endcase
      o_byte_ready <= (nxt inside {S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHK});
      o_busy       <= (nxt inside {S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHK});
      o_done       <= (nxt == S_DONE);
      o_err        <= (nxt == S_ERR);
      o_cpu_rst    <= (nxt != S_DONE);
    end
  end

  // Once released, the cpu owns the RAM with no added latency.
  assign o_mem_en    = o_done ? i_cpu_mem_en   : wr.en;
  assign o_mem_rd_en = o_done & i_cpu_mem_rd_en;
  assign o_mem_addr  = o_done ? i_cpu_mem_addr : wr.addr;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    boot_loader_lane u_lane (
      .sel_cpu (o_done),
      .cpu_di  (i_cpu_mem_di[l]),
      .cpu_we  (i_cpu_mem_wr_en[l]),
      .ldr_di  (wr.di[l]),
      .ldr_we  (wr.en),
      .mem_di  (o_mem_di[l]),
      .mem_we  (o_mem_wr_en[l])
    );
  end
endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader: an image-level model predicts every output each
// cycle; directed tests pin the model with literal write lists and status.
module tb_boot_loader;
  localparam int DEPTH = 4096;
  localparam int AW    = 13;

  logic           clk = 0, rst = 1;
  logic           start = 0, bypass = 0;
  logic [7:0]     bval = 0;
  logic           bvld = 0, brdy;
  logic [0:1][7:0] cpu_di, mem_di;
  logic [AW-1:0]  cpu_addr, mem_addr;
  logic           cpu_en, cpu_rd, mem_en, mem_rd;
  logic [0:1]     cpu_we, mem_we;
  logic           cpu_rst, busy, done, err;

  boot_loader #(.MEM_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .i_start(start), .i_bypass(bypass),
    .i_byte(bval), .i_byte_valid(bvld), .o_byte_ready(brdy),
    .i_cpu_mem_di(cpu_di), .i_cpu_mem_addr(cpu_addr), .i_cpu_mem_en(cpu_en),
    .i_cpu_mem_rd_en(cpu_rd), .i_cpu_mem_wr_en(cpu_we),
    .o_mem_di(mem_di), .o_mem_addr(mem_addr), .o_mem_en(mem_en),
    .o_mem_rd_en(mem_rd), .o_mem_wr_en(mem_we),
    .o_cpu_rst(cpu_rst), .o_busy(busy), .o_done(done), .o_err(err)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0, n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // ---------------- image-level model ----------------
  typedef enum {P_IDLE, P_LOAD, P_DONE, P_ERR} phase_t;
  phase_t        m_phase = P_IDLE;
  logic [7:0]    acc[$];
  bit            model_ok = 0;
  logic          m_wen = 0;
  logic [AW-1:0] m_waddr = '0;
  logic [15:0]   m_wdata = '0;
  logic [28:0]   wlog[$];   // {addr, data} of every loader write seen

  always @(negedge clk) begin
    logic [63:0] act, exp;
    logic [15:0] n;
    logic [7:0]  x;
    int          k;
    if (model_ok) begin
      act = {26'd0, brdy, busy, done, err, cpu_rst, mem_en, mem_rd, mem_we, mem_addr, mem_di};
      exp = {26'd0, m_phase == P_LOAD, m_phase == P_LOAD, m_phase == P_DONE,
             m_phase == P_ERR, m_phase != P_DONE, 33'd0};
      if (m_phase == P_DONE)
        exp[32:0] = {cpu_en, cpu_rd, cpu_we, cpu_addr, cpu_di};
      else if (m_wen)
        exp[32:0] = {1'b1, 1'b0, 2'b11, m_waddr, m_wdata};
      check("cycle", act, exp);
      if (mem_en && !done) wlog.push_back({mem_addr, mem_di});
    end
    // advance to the state after the coming edge
    m_wen = 0;
    if (rst) begin
      m_phase = P_IDLE; acc.delete(); model_ok = 1;
    end else if (model_ok) begin
      case (m_phase)
        P_IDLE: if (start) begin m_phase = P_LOAD; acc.delete(); end
                else if (bypass) m_phase = P_DONE;
        P_ERR:  if (start) begin m_phase = P_LOAD; acc.delete(); end
        P_LOAD: if (bvld) begin
          acc.push_back(bval);
          k = acc.size();
          n = {acc[0], (k > 1) ? acc[1] : 8'h00};
          if (k == 2) begin
            if (int'(n) > DEPTH) m_phase = P_ERR;
          end else if (k > 2) begin
            if (k % 2 == 0 && k <= 2 + 2 * int'(n)) begin
              m_wen = 1; m_waddr = AW'(k - 4); m_wdata = {acc[k-2], acc[k-1]};
            end
            if (k == 3 + 2 * int'(n)) begin
              x = 0;
              for (int i = 2; i < k - 1; i++) x ^= acc[i];
              m_phase = (acc[k-1] == x) ? P_DONE : P_ERR;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0] img[$];

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_rst();
    rst = 1; cyc(2); rst = 0; wlog.delete();
  endtask

  task automatic pulse_start();
    start = 1; cyc(); start = 0;
  endtask

  task automatic send(input int gap_max, input int upto);
    int lim = (upto < 0) ? img.size() : upto;
    for (int i = 0; i < lim; i++) begin
      repeat ($urandom_range(gap_max, 0)) begin bvld = 0; cyc(); end
      bvld = 1; bval = img[i]; cyc();
    end
    bvld = 0;
  endtask

  task automatic check_img1(input string tag);
    check({tag, "_nwr"}, 64'(wlog.size()), 64'd2);
    check({tag, "_w0"},  64'(wlog[0]), 64'({13'h0, 16'h1234}));
    check({tag, "_w1"},  64'(wlog[1]), 64'({13'h2, 16'hABCD}));
    check({tag, "_done"}, 64'({done, cpu_rst, err}), 64'b100);
  endtask

  initial begin
    logic [7:0] x;
    // cpu-side noise: must be invisible until the cpu is released
    cpu_en = 1; cpu_rd = 1; cpu_we = 2'b11; cpu_addr = 13'h155; cpu_di = 16'hDEAD;

    do_rst();
    check("rst_state", 64'({cpu_rst, brdy, busy, done, err, mem_en, mem_we, mem_addr, mem_di}),
          64'({1'b1, 36'd0}));

    // 1: basic two-halfword image
    img = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    pulse_start(); send(0, -1); cyc(2);
    check_img1("t1");

    // 2: empty image, then cpu pass-through
    do_rst();
    img = '{8'h00, 8'h00, 8'h00};
    pulse_start(); send(0, -1); cyc(2);
    check("t2_nwr", 64'(wlog.size()), 64'd0);
    check("t2_done", 64'(done), 64'd1);
    cpu_en = 1; cpu_rd = 0; cpu_we = 2'b01; cpu_addr = 13'd6; cpu_di = 16'h5A5A;
    #1;
    check("t2_pass", 64'({mem_en, mem_rd, mem_we, mem_addr, mem_di}),
          64'({1'b1, 1'b0, 2'b01, 13'd6, 16'h5A5A}));
    cyc(2);
    cpu_en = 1; cpu_rd = 1; cpu_we = 2'b11; cpu_addr = 13'h155; cpu_di = 16'hDEAD;

    // 3: bad checksum, then retry from ERR
    do_rst();
    img = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
    pulse_start(); send(0, -1); cyc(2);
    check("t3_err", 64'({err, cpu_rst, done, busy}), 64'b1100);
    img[6] = 8'h40; wlog.delete();
    pulse_start();
    check("t3_retry", 64'({busy, err}), 64'b10);
    send(0, -1); cyc(2);
    check_img1("t3");

    // 4: length over depth
    do_rst();
    img = '{8'h10, 8'h01};
    pulse_start(); send(0, -1);
    check("t4_err", 64'({err, busy, cpu_rst}), 64'b101);
    cyc(3);
    check("t4_nwr", 64'(wlog.size()), 64'd0);

    // 4b: length exactly the depth fills RAM
    do_rst();
    img = '{8'h10, 8'h00};
    x = 0;
    for (int i = 0; i < 2 * DEPTH; i++) begin
      img.push_back(8'((i * 7 + 3) & 255)); x ^= 8'((i * 7 + 3) & 255);
    end
    img.push_back(x);
    pulse_start(); send(0, -1); cyc(2);
    check("t4b_nwr", 64'(wlog.size()), 64'(DEPTH));
    check("t4b_last", 64'(wlog[DEPTH-1]), 64'({13'd8190, 8'((8190*7+3) & 255), 8'((8191*7+3) & 255)}));
    check("t4b_done", 64'(done), 64'd1);

    // 5: same image with valid gaps, then reset mid-load
    do_rst();
    img = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    pulse_start(); send(5, -1); cyc(2);
    check_img1("t5");
    do_rst();
    pulse_start(); send(0, 4);
    rst = 1; cyc(); rst = 0;
    check("t5_abort", 64'({busy, brdy, mem_en, cpu_rst}), 64'b0001);
    send(0, -1); cyc(3);
    check("t5_nwr", 64'(wlog.size()), 64'd1);
    check("t5_idle", 64'({busy, done, err}), 64'b000);

    // 6: start beats bypass; bypass alone releases
    do_rst();
    start = 1; bypass = 1; cyc(); start = 0; bypass = 0;
    check("t6_both", 64'({busy, done}), 64'b10);
    do_rst();
    bypass = 1; cyc(); bypass = 0;
    check("t6_bypass", 64'({done, cpu_rst, busy}), 64'b100);
    pulse_start(); cyc();
    check("t6_stay", 64'({done, busy}), 64'b10);
    check("t6_nwr", 64'(wlog.size()), 64'd0);

    cyc(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
